// File: rtl/reorder_buffer_if.sv
// Reorder buffer port bundle: decode issue, writeback, commit, flush and operand query.
// slave = the reorder buffer itself, master = surrounding core / testbench.
interface reorder_buffer_if #(
  parameter int ROB_WIDTH = 3,
  parameter int REG_WIDTH = 5
);
  logic                 flush;
  logic [31:0]          flush_pc;
  logic                 dec_valid;
  logic [REG_WIDTH-1:0] dec_reg_id;
  logic                 dec_is_branch;
  logic [31:0]          dec_alt_pc;
  logic                 dec_full;
  logic [ROB_WIDTH-1:0] dec_rob_id;
  logic                 wb_valid;
  logic [ROB_WIDTH-1:0] wb_rob_id;
  logic [31:0]          wb_data;
  logic                 wb_mispredict;
  logic [REG_WIDTH-1:0] commit_reg_id;
  logic [31:0]          commit_data;
  logic [ROB_WIDTH-1:0] commit_rob_id;
  logic [ROB_WIDTH-1:0] rob_id_j;
  logic [ROB_WIDTH-1:0] rob_id_k;
  logic                 ready_j;
  logic                 ready_k;
  logic [31:0]          data_j;
  logic [31:0]          data_k;

  modport slave (
    input  dec_valid, dec_reg_id, dec_is_branch, dec_alt_pc,
    input  wb_valid, wb_rob_id, wb_data, wb_mispredict,
    input  rob_id_j, rob_id_k,
    output flush, flush_pc, dec_full, dec_rob_id,
    output commit_reg_id, commit_data, commit_rob_id,
    output ready_j, ready_k, data_j, data_k
  );

  modport master (
    output dec_valid, dec_reg_id, dec_is_branch, dec_alt_pc,
    output wb_valid, wb_rob_id, wb_data, wb_mispredict,
    output rob_id_j, rob_id_k,
    input  flush, flush_pc, dec_full, dec_rob_id,
    input  commit_reg_id, commit_data, commit_rob_id,
    input  ready_j, ready_k, data_j, data_k
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue; writeback-to-retire >= 1 cycle, commit/flush registered.
// Backpressure: dec_full stalls the decoder; rdy_in low freezes all state.
module reorder_buffer #(
  parameter int ROB_WIDTH = 3,
  parameter int REG_WIDTH = 5
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  reorder_buffer_if.slave  bus
);
  localparam int ROB_SIZE = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH:0]   FULL_CNT = (ROB_WIDTH+1)'(ROB_SIZE);
  localparam logic [ROB_WIDTH-1:0] IDX_ONE  = {{(ROB_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ROB_WIDTH:0]   CNT_ONE  = {{ROB_WIDTH{1'b0}}, 1'b1};

  logic [ROB_SIZE-1:0]  r_busy;
  logic [ROB_SIZE-1:0]  r_ready;
  logic [ROB_SIZE-1:0]  r_is_br;
  logic [ROB_SIZE-1:0]  r_mispred;
  logic [REG_WIDTH-1:0] r_reg_id [ROB_SIZE];
  logic [31:0]          r_data   [ROB_SIZE];
  logic [31:0]          r_alt_pc [ROB_SIZE];
  logic [ROB_WIDTH-1:0] r_head;
  logic [ROB_WIDTH-1:0] r_tail;
  logic [ROB_WIDTH:0]   r_count;
  logic                 r_flush;
  logic [31:0]          r_flush_pc;
  logic [REG_WIDTH-1:0] r_commit_reg_id;
  logic [31:0]          r_commit_data;
  logic [ROB_WIDTH-1:0] r_commit_rob_id;

  logic w_full, w_active, w_issue, w_wb, w_retire, w_redirect;
  logic w_hit_j, w_hit_k;

  assign w_full     = (r_count == FULL_CNT);
  assign w_active   = rdy_in & ~r_flush;
  assign w_issue    = bus.dec_valid & ~w_full & w_active;
  assign w_wb       = bus.wb_valid & w_active & r_busy[bus.wb_rob_id];
  // Retire looks only at the stored ready bit, never the writeback bypass.
  assign w_retire   = w_active & r_busy[r_head] & r_ready[r_head];
  assign w_redirect = w_retire & r_is_br[r_head] & r_mispred[r_head];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_head          <= '0;
      r_tail          <= '0;
      r_count         <= '0;
      r_busy          <= '0;
      r_ready         <= '0;
      r_flush         <= 1'b0;
      r_flush_pc      <= '0;
      r_commit_reg_id <= '0;
      r_commit_data   <= '0;
      r_commit_rob_id <= '0;
    end else if (r_flush) begin
      r_head          <= '0;
      r_tail          <= '0;
      r_count         <= '0;
      r_busy          <= '0;
      r_ready         <= '0;
      r_flush         <= 1'b0;
      r_commit_reg_id <= '0;
    end else begin
      r_flush         <= 1'b0;
      r_commit_reg_id <= '0;
      if (w_issue) begin
        r_tail          <= r_tail + IDX_ONE;
        r_busy[r_tail]  <= 1'b1;
        r_ready[r_tail] <= 1'b0;
      end
      if (w_wb) begin
        r_ready[bus.wb_rob_id] <= 1'b1;
      end
      if (w_retire) begin
        r_head          <= r_head + IDX_ONE;
        r_busy[r_head]  <= 1'b0;
        r_ready[r_head] <= 1'b0;
        r_commit_reg_id <= r_reg_id[r_head];
        r_commit_data   <= r_data[r_head];
        r_commit_rob_id <= r_head;
        r_flush         <= w_redirect;
        if (w_redirect) begin
          r_flush_pc <= r_alt_pc[r_head];
        end
      end
      if (w_issue && !w_retire) begin
        r_count <= r_count + CNT_ONE;
      end else if (!w_issue && w_retire) begin
        r_count <= r_count - CNT_ONE;
      end
    end
  end

  // Payload fields are only meaningful while busy, so flush leaves them alone.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_is_br   <= '0;
      r_mispred <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        r_reg_id[i] <= '0;
        r_data[i]   <= '0;
        r_alt_pc[i] <= '0;
      end
    end else begin
      if (w_issue) begin
        r_reg_id[r_tail]  <= bus.dec_reg_id;
        r_is_br[r_tail]   <= bus.dec_is_branch;
        r_alt_pc[r_tail]  <= bus.dec_alt_pc;
        r_mispred[r_tail] <= 1'b0;
      end
      if (w_wb) begin
        r_data[bus.wb_rob_id]    <= bus.wb_data;
        r_mispred[bus.wb_rob_id] <= bus.wb_mispredict;
      end
    end
  end

  assign w_hit_j = bus.wb_valid & (bus.wb_rob_id == bus.rob_id_j);
  assign w_hit_k = bus.wb_valid & (bus.wb_rob_id == bus.rob_id_k);

  assign bus.ready_j = r_busy[bus.rob_id_j] & (r_ready[bus.rob_id_j] | w_hit_j);
  assign bus.ready_k = r_busy[bus.rob_id_k] & (r_ready[bus.rob_id_k] | w_hit_k);
  assign bus.data_j  = w_hit_j ? bus.wb_data : r_data[bus.rob_id_j];
  assign bus.data_k  = w_hit_k ? bus.wb_data : r_data[bus.rob_id_k];

  assign bus.dec_full      = w_full;
  assign bus.dec_rob_id    = r_tail;
  assign bus.flush         = r_flush;
  assign bus.flush_pc      = r_flush_pc;
  assign bus.commit_reg_id = r_commit_reg_id;
  assign bus.commit_data   = r_commit_data;
  assign bus.commit_rob_id = r_commit_rob_id;
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: commits and flushes are checked by a negedge monitor
// against queues filled by the stimulus; combinational/state outputs are checked inline.
module tb_reorder_buffer;
  logic clk;
  logic rst_n;
  logic rdy;

  typedef struct {
    logic [4:0]  reg_id;
    logic [31:0] data;
    logic [2:0]  rob_id;
  } commit_t;

  commit_t     exp_q[$];
  logic [31:0] flush_q[$];
  commit_t     mon_e;
  logic [31:0] mon_pc;
  int          checks;
  int          failures;

  reorder_buffer_if #(.ROB_WIDTH(3), .REG_WIDTH(5)) u_if ();

  reorder_buffer #(.ROB_WIDTH(3), .REG_WIDTH(5)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .rdy_in (rdy),
    .bus    (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] r, input logic br, input logic [31:0] alt);
    u_if.dec_valid     = 1'b1;
    u_if.dec_reg_id    = r;
    u_if.dec_is_branch = br;
    u_if.dec_alt_pc    = alt;
    cyc();
    u_if.dec_valid     = 1'b0;
    u_if.dec_is_branch = 1'b0;
  endtask

  task automatic wb(input logic [2:0] id, input logic [31:0] d, input logic mis);
    u_if.wb_valid      = 1'b1;
    u_if.wb_rob_id     = id;
    u_if.wb_data       = d;
    u_if.wb_mispredict = mis;
    cyc();
    u_if.wb_valid      = 1'b0;
    u_if.wb_mispredict = 1'b0;
  endtask

  task automatic push_commit(input logic [4:0] r, input logic [31:0] d, input logic [2:0] id);
    commit_t e;
    e.reg_id = r;
    e.data   = d;
    e.rob_id = id;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (u_if.commit_reg_id != 5'd0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_commit", 32'(u_if.commit_reg_id), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("commit_reg_id", 32'(u_if.commit_reg_id), 32'(mon_e.reg_id));
        chk("commit_data", u_if.commit_data, mon_e.data);
        chk("commit_rob_id", 32'(u_if.commit_rob_id), 32'(mon_e.rob_id));
      end
    end
    if (u_if.flush) begin
      if (flush_q.size() == 0) begin
        chk("unexpected_flush", 32'(u_if.flush), 32'd0);
      end else begin
        mon_pc = flush_q.pop_front();
        chk("flush_pc", u_if.flush_pc, mon_pc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks             = 0;
    failures           = 0;
    rst_n              = 1'b0;
    rdy                = 1'b1;
    u_if.dec_valid     = 1'b0;
    u_if.dec_reg_id    = '0;
    u_if.dec_is_branch = 1'b0;
    u_if.dec_alt_pc    = '0;
    u_if.wb_valid      = 1'b0;
    u_if.wb_rob_id     = '0;
    u_if.wb_data       = '0;
    u_if.wb_mispredict = 1'b0;
    u_if.rob_id_j      = '0;
    u_if.rob_id_k      = '0;
    repeat (2) cyc();
    chk("rst_dec_full", 32'(u_if.dec_full), 32'd0);
    chk("rst_dec_rob_id", 32'(u_if.dec_rob_id), 32'd0);
    chk("rst_commit_reg_id", 32'(u_if.commit_reg_id), 32'd0);
    chk("rst_flush", 32'(u_if.flush), 32'd0);
    chk("rst_flush_pc", u_if.flush_pc, 32'd0);
    rst_n = 1'b1;
    cyc();

    // Fill all eight entries, then try a ninth issue while full.
    for (int i = 0; i < 8; i++) begin
      chk("fill_dec_rob_id", 32'(u_if.dec_rob_id), 32'(i));
      chk("fill_not_full", 32'(u_if.dec_full), 32'd0);
      issue(5'(i + 1), 1'b0, 32'd0);
    end
    chk("full_after_8", 32'(u_if.dec_full), 32'd1);
    chk("tail_wrapped", 32'(u_if.dec_rob_id), 32'd0);
    issue(5'd9, 1'b0, 32'd0);
    chk("full_after_9th", 32'(u_if.dec_full), 32'd1);
    chk("tail_after_9th", 32'(u_if.dec_rob_id), 32'd0);

    // Same-cycle writeback bypass on the query ports.
    u_if.rob_id_j      = 3'd4;
    u_if.rob_id_k      = 3'd5;
    u_if.wb_valid      = 1'b1;
    u_if.wb_rob_id     = 3'd4;
    u_if.wb_data       = 32'hDEAD;
    #1;
    chk("bypass_ready_j", 32'(u_if.ready_j), 32'd1);
    chk("bypass_data_j", u_if.data_j, 32'hDEAD);
    chk("notready_k", 32'(u_if.ready_k), 32'd0);
    cyc();
    u_if.wb_valid = 1'b0;
    u_if.rob_id_k = 3'd4;
    #1;
    chk("stored_ready_k", 32'(u_if.ready_k), 32'd1);
    chk("stored_data_k", u_if.data_k, 32'hDEAD);

    // Out-of-order writeback, in-order retirement on consecutive cycles.
    push_commit(5'd1, 32'h00, 3'd0);
    push_commit(5'd2, 32'h11, 3'd1);
    push_commit(5'd3, 32'h22, 3'd2);
    wb(3'd2, 32'h22, 1'b0);
    chk("no_retire_head_not_ready", 32'(u_if.commit_reg_id), 32'd0);
    wb(3'd0, 32'h00, 1'b0);
    chk("no_same_cycle_retire", 32'(u_if.commit_reg_id), 32'd0);
    wb(3'd1, 32'h11, 1'b0);
    chk("retire_1", 32'(u_if.commit_reg_id), 32'd1);
    cyc();
    chk("retire_2", 32'(u_if.commit_reg_id), 32'd2);
    cyc();
    chk("retire_3", 32'(u_if.commit_reg_id), 32'd3);
    cyc();
    chk("retire_stall_at_3", 32'(u_if.commit_reg_id), 32'd0);
    issue(5'd9, 1'b0, 32'd0);
    chk("tail_before_reset", 32'(u_if.dec_rob_id), 32'd1);

    // Asynchronous reset in the middle of traffic.
    u_if.dec_valid = 1'b1;
    u_if.rob_id_j  = 3'd4;
    rst_n          = 1'b0;
    #2;
    chk("mid_rst_commit", 32'(u_if.commit_reg_id), 32'd0);
    chk("mid_rst_flush", 32'(u_if.flush), 32'd0);
    chk("mid_rst_dec_full", 32'(u_if.dec_full), 32'd0);
    chk("mid_rst_dec_rob_id", 32'(u_if.dec_rob_id), 32'd0);
    chk("mid_rst_entry_gone", 32'(u_if.ready_j), 32'd0);
    cyc();
    u_if.dec_valid = 1'b0;
    rst_n          = 1'b1;
    cyc();

    // Mispredicted branch at id3; younger ids 4 and 5 must never commit.
    issue(5'd10, 1'b0, 32'd0);
    issue(5'd11, 1'b0, 32'd0);
    issue(5'd12, 1'b0, 32'd0);
    issue(5'd13, 1'b1, 32'h100);
    issue(5'd14, 1'b0, 32'd0);
    issue(5'd15, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) push_commit(5'(10 + i), 32'hA0 + 32'(i), 3'(i));
    flush_q.push_back(32'h100);
    wb(3'd0, 32'hA0, 1'b0);
    wb(3'd1, 32'hA1, 1'b1);
    wb(3'd2, 32'hA2, 1'b0);
    chk("nonbranch_mispredict_no_flush", 32'(u_if.flush), 32'd0);
    wb(3'd3, 32'hA3, 1'b1);
    wb(3'd4, 32'hA4, 1'b0);
    chk("flush_raised", 32'(u_if.flush), 32'd1);
    chk("flush_pc_value", u_if.flush_pc, 32'h100);
    chk("branch_reg_commits", 32'(u_if.commit_reg_id), 32'd13);
    wb(3'd5, 32'hA5, 1'b0);
    chk("flush_one_cycle", 32'(u_if.flush), 32'd0);
    chk("post_flush_rob_id", 32'(u_if.dec_rob_id), 32'd0);
    chk("post_flush_full", 32'(u_if.dec_full), 32'd0);
    chk("post_flush_commit", 32'(u_if.commit_reg_id), 32'd0);
    repeat (3) cyc();

    // Ready head held by rdy_in low for three cycles.
    issue(5'd20, 1'b0, 32'd0);
    push_commit(5'd20, 32'h66, 3'd0);
    wb(3'd0, 32'h66, 1'b0);
    rdy             = 1'b0;
    u_if.dec_valid  = 1'b1;
    u_if.dec_reg_id = 5'd21;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("freeze_no_commit", 32'(u_if.commit_reg_id), 32'd0);
      chk("freeze_tail", 32'(u_if.dec_rob_id), 32'd1);
    end
    rdy            = 1'b1;
    u_if.dec_valid = 1'b0;
    cyc();
    chk("unfreeze_retire", 32'(u_if.commit_reg_id), 32'd20);
    repeat (3) cyc();

    chk("commit_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("flush_queue_drained", 32'(flush_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
